// File: rtl/rr_arb_4to1.sv
// Four-channel round-robin arbiter feeding a single-entry registered output stage.
// The pointer rotates past each winner so every requester is served within four transfers.
module rr_arb_4to1 #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [3:0]        in_valid,
    output logic [3:0]        in_ready,
    output logic [DATA_W-1:0] out,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] out_q, out_d;
    logic [1:0]        sel_q, sel_d;
    logic              valid_q, valid_d;
    logic [1:0]        ptr_q, ptr_d;

    logic [1:0]        idx;
    logic [1:0]        cand;
    logic              found;
    logic              load;
    logic [DATA_W-1:0] win_data;

    // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requester wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        idx   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    // Reset suppresses acceptance so no item is lost in the reset cycle.
    assign load = found & (~valid_q | out_ready) & ~rst;

    always_comb begin
        in_ready      = 4'b0000;
        in_ready[idx] = load;
    end

    always_comb begin
        win_data = a;
        case (idx)
            2'd0: win_data = a;
            2'd1: win_data = b;
            2'd2: win_data = c;
            2'd3: win_data = d;
            default: win_data = a;
        endcase
    end

    always_comb begin
        out_d   = out_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            out_d   = win_data;
            sel_d   = idx;
            valid_d = 1'b1;
            ptr_d   = idx + 2'd1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            ptr_q   <= 2'b00;
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed self-checking bench for rr_arb_4to1: reset, rotation, single requester,
// pointer wrap, backpressure stall and reset in the middle of a held item.
module tb_rr_arb_4to1;

    localparam int DATA_W = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] a, b, c, d;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [DATA_W-1:0] out;
    logic [1:0]        out_sel;
    logic              out_valid;
    logic              out_ready;

    int checks;
    int failures;

    rr_arb_4to1 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out !== 4'd0 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b out=%0d sel=%0d expected 0/0/0", out_valid, out, out_sel);
        end
        rst = 1'b0; in_valid = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL idle_in_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b0 || out !== 4'd0 || out_sel !== 2'd0) begin
                failures++;
                $display("FAIL idle_state[%0d]: got valid=%b out=%0d sel=%0d expected 0/0/0", i, out_valid, out, out_sel);
            end
        end
    endtask

    // ptr starts at 0: grants 0,1,2,3,0,1,2,3; then drain leaves ptr at 0.
    task automatic test_rotation();
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (in_ready !== (4'b0001 << (i % 4))) begin
                failures++;
                $display("FAIL rot_in_ready[%0d]: got %b expected %b", i, in_ready, 4'b0001 << (i % 4));
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out !== 4'((i % 4) + 1)) begin
                failures++;
                $display("FAIL rot_out[%0d]: got valid=%b sel=%0d out=%0d expected 1/%0d/%0d",
                         i, out_valid, out_sel, out, i % 4, (i % 4) + 1);
            end
        end
        in_valid = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd3 || out !== 4'd4) begin
            failures++;
            $display("FAIL drain_hold: got valid=%b sel=%0d out=%0d expected 0/3/4", out_valid, out_sel, out);
        end
    endtask

    // Only channel 2 requests with ptr=0; afterwards ptr=3.
    task automatic test_single();
        c = 4'd9; in_valid = 4'b0100; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_in_ready[%0d]: got %b expected 0100", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out !== 4'd9) begin
                failures++;
                $display("FAIL single_out[%0d]: got valid=%b sel=%0d out=%0d expected 1/2/9", i, out_valid, out_sel, out);
            end
        end
        in_valid = 4'b0000;
        step();
    endtask

    // ptr=3 with channels 0 and 3 requesting: 3 first, wrap, then 0. Leaves ptr=1.
    task automatic test_wrap();
        a = 4'd5; d = 4'd7; in_valid = 4'b1001; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_in_ready0: got %b expected 1000", in_ready);
        end
        step();
        checks++;
        if (out_sel !== 2'd3 || out !== 4'd7) begin
            failures++;
            $display("FAIL wrap_out0: got sel=%0d out=%0d expected 3/7", out_sel, out);
        end
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_in_ready1: got %b expected 0001", in_ready);
        end
        step();
        checks++;
        if (out_sel !== 2'd0 || out !== 4'd5) begin
            failures++;
            $display("FAIL wrap_out1: got sel=%0d out=%0d expected 0/5", out_sel, out);
        end
        in_valid = 4'b0000;
        step();
    endtask

    // ptr=1: load channel 1, stall 3 cycles, then release grants channel 2.
    task automatic test_stall();
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        in_valid = 4'b1111; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_first_in_ready: got %b expected 0010", in_ready);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0000", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd1 || out !== 4'd2) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got valid=%b sel=%0d out=%0d expected 1/1/2", i, out_valid, out_sel, out);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("FAIL stall_release_in_ready: got %b expected 0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out !== 4'd3) begin
            failures++;
            $display("FAIL stall_release_out: got valid=%b sel=%0d out=%0d expected 1/2/3", out_valid, out_sel, out);
        end
        in_valid = 4'b0000;
        step();
    endtask

    // ptr=3: hold channel 0's item (ptr->1), then reset; post-reset grant must be channel 0.
    task automatic test_reset_mid();
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        in_valid = 4'b0001; out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out !== 4'd1) begin
            failures++;
            $display("FAIL rmid_load: got valid=%b sel=%0d out=%0d expected 1/0/1", out_valid, out_sel, out);
        end
        rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_in_ready: got %b expected 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out !== 4'd0 || out_sel !== 2'd0) begin
            failures++;
            $display("FAIL rmid_state: got valid=%b out=%0d sel=%0d expected 0/0/0", out_valid, out, out_sel);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rmid_grant_in_ready: got %b expected 0001", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out !== 4'd1) begin
            failures++;
            $display("FAIL rmid_grant_out: got valid=%b sel=%0d out=%0d expected 1/0/1", out_valid, out_sel, out);
        end
        in_valid = 4'b0000;
        step();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_single();
        test_wrap();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
